sr_lock_arbiter: RTL and testbench

Round-robin arbiter that shares one SR-flop lock flag between N_REQ requesters.
- Grants exclusive ownership of the lock to one requester at a time.
- Sets the lock flag on grant and clears it on release or timeout.
- Sits in front of the SR flag resource as its sole sequencer: no requester drives the flag's s/r directly.

---
 rtl/sr_arb_pkg.sv | 37 +++
 rtl/sr_lock_cell.sv | 35 +++
 rtl/sr_lock_arbiter.sv | 127 ++++++++++++
 tb/tb_sr_lock_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sr_arb_pkg.sv
// Shared types and helpers for the SR-lock round-robin arbiter.
//   state_t     : arbiter FSM states
//   clog2_min1  : $clog2 clamped to a minimum of 1, for derived widths
//   rr_first    : first asserted request at or after a pointer, with wrap
package sr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Upper bound on requesters that rr_first can scan.
  localparam int RR_MAX = 64;

  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

  // Returns the index of the first set bit in req[n-1:0], searching from ptr
  // upward modulo n, or -1 when no bit is set. The scan runs from the farthest
  // offset down, so the nearest match is the one left in the result.
  function automatic int rr_first(input logic [RR_MAX-1:0] req,
                                  input int ptr, input int n);
    int idx;
    rr_first = -1;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (req[idx]) rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/sr_lock_cell.sv
// Set/reset flag cell with asynchronous active-low reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q
//   s, r  : set / reset strobes; both low holds the flag; both high is illegal
//   q     : flag value
//   qbar  : inverted flag value
module sr_lock_cell
  (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar
  );

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (s) begin
      r_q <= 1'b1;
    end else if (r) begin
      r_q <= 1'b0;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

  // The sequencer must never request set and reset together.
  a_no_set_and_reset: assert property (@(posedge clk) disable iff (!rst_n) !(s && r));

endmodule

// File: rtl/sr_lock_arbiter.sv
// Round-robin arbiter that owns the only set/reset path into a shared lock
// flag. One requester at a time receives the lock; it is returned on the
// owner's release strobe or forcibly after TIMEOUT held cycles.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   req     : level request per requester
//   rel     : release strobe per requester (only the owner's bit matters)
//   gnt     : one-hot grant, zero while the lock is free
//   busy    : lock flag (q of the SR cell)
//   owner   : index of the current / most recent grantee
//   timeout : one-cycle pulse on a forced release
module sr_lock_arbiter
  import sr_arb_pkg::*;
  #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 16,
    localparam int OW      = clog2_min1(N_REQ),
    localparam int CW      = clog2_min1(TIMEOUT + 1)
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic [OW-1:0]    owner,
    output logic             timeout
  );

  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t           r_state;
  logic [OW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [OW-1:0]    r_owner;
  logic             r_timeout;

  logic [RR_MAX-1:0] w_req_ext;
  int                w_pick;
  logic [OW-1:0]     w_win;
  logic [OW-1:0]     w_ptr_nxt;
  logic              w_any;
  logic              w_rel_own;
  logic              w_to_hit;
  logic              w_set;
  logic              w_clr;
  logic              w_q;
  logic              w_qbar;

  assign w_req_ext = RR_MAX'(req);
  assign w_any     = |req;

  always_comb begin
    w_pick    = rr_first(w_req_ext, int'(r_ptr), N_REQ);
    w_win     = OW'(w_pick);
    w_ptr_nxt = ((w_pick + 1) >= N_REQ) ? '0 : OW'(w_pick + 1);
  end

  // r_gnt is one-hot on the owner while HELD, so masking rel with it picks
  // out the owner's strobe and ignores everyone else.
  assign w_rel_own = |(rel & r_gnt);
  assign w_to_hit  = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Set only leaves IDLE/RECOVER (where the flag is already clear), reset only
  // leaves HELD, so the two strobes are mutually exclusive by construction.
  assign w_set = (r_state != HELD) && w_any && w_qbar;
  assign w_clr = (r_state == HELD) && (w_rel_own || w_to_hit);

  sr_lock_cell u_cell (
    .clk   (clk),
    .rst_n (reset),
    .s     (w_set),
    .r     (w_clr),
    .q     (w_q),
    .qbar  (w_qbar)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RECOVER: begin
          r_timeout <= 1'b0;
          if (w_set) begin
            r_state <= HELD;
            r_gnt   <= N_REQ'(1) << w_win;
            r_owner <= w_win;
            r_cnt   <= '0;
            r_ptr   <= w_ptr_nxt;
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
          end
        end
        HELD: begin
          if (w_clr) begin
            r_state   <= RECOVER;
            r_gnt     <= '0;
            // An owner release in the same cycle as the limit wins: no pulse.
            r_timeout <= !w_rel_own;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= '0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = w_q;
  assign owner   = r_owner;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
module tb_sr_lock_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  sr_lock_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set and reset of the lock cell must never be requested together.
  always @(posedge clk) begin
    if (reset && dut.u_cell.s && dut.u_cell.r) begin
      errors++;
      $display("FAIL sr_both_high: s=%b r=%b required not both 1", dut.u_cell.s, dut.u_cell.r);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    reset = 1'b0;
    req   = 4'b1111;
    rel   = 4'b0000;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b required 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d required 0", owner); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b required 0", timeout); end
    req   = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_idle_gnt: got %b required 0000", gnt); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_gnt k=%0d: got %b required %b", k, gnt, exp); end
      checks++; if (owner !== 2'(k % 4)) begin errors++; $display("FAIL rr_owner k=%0d: got %0d required %0d", k, owner, k % 4); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy k=%0d: got %b required 1", k, busy); end
      @(negedge clk);
      checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_hold1 k=%0d: got %b required %b", k, gnt, exp); end
      @(negedge clk);
      checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_hold2 k=%0d: got %b required %b", k, gnt, exp); end
      rel = exp;
      @(negedge clk);
      rel = 4'b0000;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap k=%0d: got %b required 0000", k, gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_gap_busy k=%0d: got %b required 0", k, busy); end
      if (k == 4) req = 4'b0000;
    end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_end: got %b required 0000", gnt); end
  endtask

  task automatic test_single;
    req = 4'b0100;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b required 0100", gnt); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d required 2", owner); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
    rel = 4'b0100;
    req = 4'b0000;
    @(negedge clk);
    rel = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_rel_gnt: got %b required 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_rel_busy: got %b required 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL single_rel_timeout: got %b required 0", timeout); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner_kept: got %0d required 2", owner); end
    @(negedge clk);
  endtask

  task automatic test_non_owner_release;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL nonown_gnt: got %b required 0001", gnt); end
    rel = 4'b1110;
    req = 4'b1110;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL nonown_hold n=%0d: got %b required 0001", n, gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nonown_busy n=%0d: got %b required 1", n, busy); end
    end
    rel = 4'b0001;
    req = 4'b0000;
    @(negedge clk);
    rel = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL nonown_rel: got %b required 0000", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL nonown_timeout: got %b required 0", timeout); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    req = 4'b0010;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) req = 4'b0000;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_hold n=%0d: got %b required 0010", n, gnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early n=%0d: got %b required 0", n, timeout); end
    end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_gnt: got %b required 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b required 0", busy); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b required 1", timeout); end
    @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len: got %b required 0", timeout); end
  endtask

  task automatic test_coincident;
    req = 4'b0001;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) req = 4'b0000;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL coin_hold n=%0d: got %b required 0001", n, gnt); end
      if (n == 16) rel = 4'b0001;
    end
    @(negedge clk);
    rel = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL coin_gnt: got %b required 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coin_busy: got %b required 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL coin_timeout: got %b required 0", timeout); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_held;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_pre: got %b required 0001", gnt); end
    #2 reset = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt: got %b required 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rmid_owner: got %0d required 0", owner); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rmid_timeout: got %b required 0", timeout); end
    req = 4'b0011;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: got %b required 0001", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse: got %b required 0", timeout); end
    rel = 4'b0001;
    req = 4'b0000;
    @(negedge clk);
    rel = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_rel: got %b required 0000", gnt); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    rel   = 4'b0000;
    test_reset();
    test_round_robin();
    test_single();
    test_non_owner_release();
    test_timeout();
    test_coincident();
    test_reset_mid_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
